// File: rtl/spi_cmd_arbiter_if.sv
// rtl/spi_cmd_arbiter_if.sv - requester/SPI pin bundle for spi_cmd_arbiter
interface spi_cmd_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_in;
  logic [8*NREQ-1:0] addr_in;
  logic [8*NREQ-1:0] data_in;
  logic [NREQ-1:0]   gnt_out;
  logic [NREQ-1:0]   done_out;
  logic [7:0]        rdata_out;
  logic              busy_out;
  logic [NREQ-1:0]   spi_scs_out;
  logic              spi_sck_out;
  logic              spi_sdo_out;
  logic              spi_sdi_in;

  modport master (
    output req_in, addr_in, data_in, spi_sdi_in,
    input  gnt_out, done_out, rdata_out, busy_out, spi_scs_out, spi_sck_out, spi_sdo_out
  );

  modport slave (
    input  req_in, addr_in, data_in, spi_sdi_in,
    output gnt_out, done_out, rdata_out, busy_out, spi_scs_out, spi_sck_out, spi_sdo_out
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - round-robin SPI command arbiter, 16-bit mode-0 frames
// Optional read capture of the last data byte: SPI_READBACK_EN.
module spi_cmd_arbiter #(
  parameter int NREQ    = 3,
  parameter int CLKDIV  = 8,
  parameter int GAP_CYC = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  spi_cmd_arbiter_if.slave  bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (CLKDIV > GAP_CYC) ? CLKDIV : GAP_CYC;
  localparam int CNTW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [4:0]        half_q, half_d;
  logic [15:0]       frame_q, frame_d;
  logic [IDXW-1:0]   win_q, win_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic              found;
  logic [IDXW-1:0]   pick;
  logic [7:0]        pick_addr, pick_data;
`ifdef SPI_READBACK_EN
  logic              rd_q, rd_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        rdata_q, rdata_d;
`endif

  // Two passes give "first requester after rr_q, wrapping" without a modulo.
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && IDXW'(i) > rr_q && bus.req_in[i]) begin
        found     = 1'b1;
        pick      = IDXW'(i);
        pick_addr = bus.addr_in[8*i +: 8];
        pick_data = bus.data_in[8*i +: 8];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && IDXW'(i) <= rr_q && bus.req_in[i]) begin
        found     = 1'b1;
        pick      = IDXW'(i);
        pick_addr = bus.addr_in[8*i +: 8];
        pick_data = bus.data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      frame_q <= '0;
      win_q   <= '0;
      rr_q    <= IDXW'(NREQ - 1);
`ifdef SPI_READBACK_EN
      rd_q    <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      frame_q <= frame_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
`ifdef SPI_READBACK_EN
      rd_q    <= rd_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    frame_d = frame_q;
    win_d   = win_q;
    rr_d    = rr_q;
`ifdef SPI_READBACK_EN
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          frame_d = {pick_addr, pick_data};
          win_d   = pick;
          rr_d    = pick;
`ifdef SPI_READBACK_EN
          rd_d    = pick_addr[7];
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == CNTW'(CLKDIV - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNTW'(CLKDIV - 1)) begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
          // Even half ends on a rising edge, odd half on a falling edge.
          if (!half_q[0]) begin
`ifdef SPI_READBACK_EN
            if (rd_q && half_q[4]) rx_d = {rx_q[6:0], bus.spi_sdi_in};
`endif
          end else if (half_q == 5'd31) begin
            state_d = S_HOLD;
          end else begin
            frame_d = {frame_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNTW'(CLKDIV - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CNTW'(GAP_CYC - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
`ifdef SPI_READBACK_EN
          if (rd_q) rdata_d = rx_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_out     = '0;
    bus.done_out    = '0;
    bus.spi_scs_out = '1;
    bus.busy_out    = (state_q != S_IDLE);
    bus.spi_sck_out = (state_q == S_SHIFT) && half_q[0];
    bus.spi_sdo_out = 1'b0;
    if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD)
      bus.spi_sdo_out = frame_q[15];
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IDXW'(i)) begin
        if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD)
          bus.spi_scs_out[i] = 1'b0;
        if (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD || state_q == S_GAP)
          bus.gnt_out[i] = 1'b1;
        if (state_q == S_DONE)
          bus.done_out[i] = 1'b1;
      end
    end
  end

`ifdef SPI_READBACK_EN
  assign bus.rdata_out = rdata_q;
`else
  assign bus.rdata_out = '0;
`endif

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// tb/tb_spi_cmd_arbiter.sv - directed vector bench for spi_cmd_arbiter
module tb_spi_cmd_arbiter;
  localparam int NREQ = 3;
  localparam int CLKDIV = 2;
  localparam int GAP_CYC = 4;
  localparam int DONE_CYC = 34*CLKDIV + GAP_CYC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_rdata = '0;

  always #5 clk = ~clk;

  spi_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_cmd_arbiter #(.NREQ(NREQ), .CLKDIV(CLKDIV), .GAP_CYC(GAP_CYC)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [2:0]  req;
    logic [23:0] addr;
    logic [23:0] data;
    logic [7:0]  sbyte;
    int          w;
    logic [15:0] frame;
    bit          mutate;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_in = '0;
    bus.spi_sdi_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
  endtask

  task automatic run_txn(input int w, input logic [15:0] frame, input logic [7:0] sbyte,
                         input bit mutate, input logic [2:0] drop, input int exp_wait);
    int wait_n, cyc, cs_low, rises, zeros;
    logic [15:0] rx;
    logic [2:0] done_v;
    logic [7:0] rd_v;
    bit overlap, prev_sck;
    wait_n = 0; cyc = 0; cs_low = 0; rises = 0; rx = '0;
    done_v = '0; rd_v = '0; overlap = 0; prev_sck = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!bus.busy_out && wait_n < 8);
    chk("grant_wait", wait_n, exp_wait);
    chk("gnt_first", {29'd0, bus.gnt_out}, 32'(1 << w));
    cyc = 1;
    while (cyc < 400) begin
      if (mutate && cyc == 1) begin
        bus.addr_in = ~bus.addr_in;
        bus.data_in = ~bus.data_in;
      end
      if (!bus.spi_scs_out[w]) cs_low++;
      zeros = 0;
      for (int i = 0; i < NREQ; i++) if (!bus.spi_scs_out[i]) zeros++;
      if (zeros > 1 || (~bus.spi_scs_out & ~(3'(1) << w)) != 3'b000) overlap = 1;
      if (bus.spi_sck_out && bus.spi_scs_out == 3'b111) overlap = 1;
      if (bus.spi_sck_out && !prev_sck) begin
        rx = {rx[14:0], bus.spi_sdo_out};
        rises++;
      end
      prev_sck = bus.spi_sck_out;
      bus.spi_sdi_in = (rises >= 8 && rises < 16) ? sbyte[15 - rises] : 1'b0;
      if (bus.done_out != '0) begin
        done_v = bus.done_out;
        rd_v = bus.rdata_out;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_in = bus.req_in & ~drop;
    bus.spi_sdi_in = 1'b0;
`ifdef SPI_READBACK_EN
    if (frame[15]) exp_rdata = sbyte;
`endif
    chk("done_onehot", {29'd0, done_v}, 32'(1 << w));
    chk("done_cycle", cyc, DONE_CYC);
    chk("rdata", {24'd0, rd_v}, {24'd0, exp_rdata});
    chk("frame", {16'd0, rx}, {16'd0, frame});
    chk("cs_low_cycles", cs_low, 34*CLKDIV);
    chk("sck_rises", rises, 16);
    chk("cs_exclusive", {31'd0, overlap}, 32'd0);
  endtask

  initial begin
    int rises;
    bit prev;
    vecs[0] = '{3'b001, 24'h000003, 24'h0000A5, 8'h00, 0, 16'h03A5, 1'b0};
    vecs[1] = '{3'b010, 24'h008100, 24'h000000, 8'h5C, 1, 16'h8100, 1'b0};
    vecs[2] = '{3'b100, 24'h120000, 24'h340000, 8'hFF, 2, 16'h1234, 1'b0};
    vecs[3] = '{3'b011, 24'h00407E, 24'h0011C3, 8'h00, 0, 16'h7EC3, 1'b0};
    vecs[4] = '{3'b110, 24'h9A5500, 24'h0F6600, 8'h00, 1, 16'h5566, 1'b0};
    vecs[5] = '{3'b101, 24'hC30001, 24'h3C0002, 8'hA7, 2, 16'hC33C, 1'b0};
    vecs[6] = '{3'b111, 24'h010203, 24'hF0E0D0, 8'h00, 0, 16'h03D0, 1'b0};
    vecs[7] = '{3'b010, 24'h00B500, 24'h009900, 8'h3E, 1, 16'hB599, 1'b1};

    bus.addr_in = '0;
    bus.data_in = '0;
    do_reset();
    chk("rst_gnt", {29'd0, bus.gnt_out}, 32'd0);
    chk("rst_done", {29'd0, bus.done_out}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("rst_rdata", {24'd0, bus.rdata_out}, 32'd0);
    chk("rst_scs", {29'd0, bus.spi_scs_out}, 32'h7);
    chk("rst_sck", {31'd0, bus.spi_sck_out}, 32'd0);
    chk("rst_sdo", {31'd0, bus.spi_sdo_out}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus.req_in = vecs[v].req;
      bus.addr_in = vecs[v].addr;
      bus.data_in = vecs[v].data;
      run_txn(vecs[v].w, vecs[v].frame, vecs[v].sbyte, vecs[v].mutate, 3'b111, 1);
    end

    // All three requesting from reset, each dropping on its own done.
    do_reset();
    bus.addr_in = 24'h128103;
    bus.data_in = 24'h3400A5;
    bus.req_in = 3'b111;
    run_txn(0, 16'h03A5, 8'h00, 1'b0, 3'b001, 1);
    run_txn(1, 16'h8100, 8'h5C, 1'b0, 3'b010, 2);
    run_txn(2, 16'h1234, 8'h00, 1'b0, 3'b100, 2);

    // 0 and 2 held continuously must alternate.
    do_reset();
    bus.req_in = 3'b101;
    run_txn(0, 16'h03A5, 8'h00, 1'b0, 3'b000, 1);
    run_txn(2, 16'h1234, 8'h00, 1'b0, 3'b000, 2);
    run_txn(0, 16'h03A5, 8'h00, 1'b0, 3'b000, 2);
    run_txn(2, 16'h1234, 8'h00, 1'b0, 3'b111, 2);

    // Reset on the 5th sck rise of a grant-1 frame.
    do_reset();
    bus.req_in = 3'b010;
    rises = 0;
    prev = 0;
    for (int c = 0; c < 200 && rises < 5; c++) begin
      @(negedge clk);
      if (bus.spi_sck_out && !prev) rises++;
      prev = bus.spi_sck_out;
    end
    chk("mid_rises", rises, 5);
    chk("mid_gnt_before", {29'd0, bus.gnt_out}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("mid_scs", {29'd0, bus.spi_scs_out}, 32'h7);
    chk("mid_sck", {31'd0, bus.spi_sck_out}, 32'd0);
    chk("mid_gnt", {29'd0, bus.gnt_out}, 32'd0);
    chk("mid_busy", {31'd0, bus.busy_out}, 32'd0);
    chk("mid_done", {29'd0, bus.done_out}, 32'd0);
    bus.req_in = 3'b011;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    run_txn(0, 16'h03A5, 8'h00, 1'b0, 3'b011, 1);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
